// File: rtl/ex_stage_pkg.sv
// Shared execute-stage definitions: bus widths, MIPS SPECIAL funct codes and
// the divider state encoding used by ex_stage and div_unit.
package ex_stage_pkg;

    localparam int BUS_W   = 32;
    localparam int REG_AW  = 5;
    localparam int FUNCT_W = 6;
    localparam int SHAMT_W = 5;

    localparam logic [FUNCT_W-1:0] F_SLL   = 6'h00;
    localparam logic [FUNCT_W-1:0] F_SRL   = 6'h02;
    localparam logic [FUNCT_W-1:0] F_SRA   = 6'h03;
    localparam logic [FUNCT_W-1:0] F_SLLV  = 6'h04;
    localparam logic [FUNCT_W-1:0] F_SRLV  = 6'h06;
    localparam logic [FUNCT_W-1:0] F_SRAV  = 6'h07;
    localparam logic [FUNCT_W-1:0] F_JALR  = 6'h09;
    localparam logic [FUNCT_W-1:0] F_MFHI  = 6'h10;
    localparam logic [FUNCT_W-1:0] F_MTHI  = 6'h11;
    localparam logic [FUNCT_W-1:0] F_MFLO  = 6'h12;
    localparam logic [FUNCT_W-1:0] F_MTLO  = 6'h13;
    localparam logic [FUNCT_W-1:0] F_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] F_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] F_DIV   = 6'h1A;
    localparam logic [FUNCT_W-1:0] F_DIVU  = 6'h1B;
    localparam logic [FUNCT_W-1:0] F_ADD   = 6'h20;
    localparam logic [FUNCT_W-1:0] F_ADDU  = 6'h21;
    localparam logic [FUNCT_W-1:0] F_SUB   = 6'h22;
    localparam logic [FUNCT_W-1:0] F_SUBU  = 6'h23;
    localparam logic [FUNCT_W-1:0] F_AND   = 6'h24;
    localparam logic [FUNCT_W-1:0] F_OR    = 6'h25;
    localparam logic [FUNCT_W-1:0] F_XOR   = 6'h26;
    localparam logic [FUNCT_W-1:0] F_NOR   = 6'h27;
    localparam logic [FUNCT_W-1:0] F_SLT   = 6'h2A;
    localparam logic [FUNCT_W-1:0] F_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// Decode-to-execute bundle: decoded operands in, ALU result, write-back
// qualification and stall request out.
interface ex_stage_if #(
    parameter int DATA_W = ex_stage_pkg::BUS_W
) ();
    logic                               flush;
    logic [ex_stage_pkg::FUNCT_W-1:0]   funct;
    logic [ex_stage_pkg::SHAMT_W-1:0]   shamt;
    logic [DATA_W-1:0]                  operand_1;
    logic [DATA_W-1:0]                  operand_2;
    logic                               write_reg_en_in;
    logic [ex_stage_pkg::REG_AW-1:0]    write_reg_addr_in;
    logic [DATA_W-1:0]                  result;
    logic                               write_reg_en_out;
    logic [ex_stage_pkg::REG_AW-1:0]    write_reg_addr_out;
    logic                               stall_req;
    logic                               overflow_exc;

    modport master (
        output flush, funct, shamt, operand_1, operand_2,
               write_reg_en_in, write_reg_addr_in,
        input  result, write_reg_en_out, write_reg_addr_out,
               stall_req, overflow_exc
    );

    modport slave (
        input  flush, funct, shamt, operand_1, operand_2,
               write_reg_en_in, write_reg_addr_in,
        output result, write_reg_en_out, write_reg_addr_out,
               stall_req, overflow_exc
    );
endinterface

// File: rtl/ex_stage_div_unit.sv
// Radix-2 restoring divider: magnitude division over DIV_ITER cycles with
// sign correction on the outputs (remainder takes the dividend's sign).
module div_unit
    import ex_stage_pkg::*;
#(
    parameter int DATA_W   = BUS_W,
    parameter int DIV_ITER = BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_en,
    input  logic              abort,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);
    localparam int               CNT_W = $clog2(DIV_ITER);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV_ITER - 1);

    div_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] q_q, r_q, d_q;
    logic              qneg_q, rneg_q, dz_q;
    logic [DATA_W-1:0] mag_a, mag_b, r_nxt;
    logic [DATA_W:0]   r_sh, r_sub;
    logic              ge;

    assign mag_a = (signed_en && dividend[DATA_W-1]) ? -dividend : dividend;
    assign mag_b = (signed_en && divisor[DATA_W-1])  ? -divisor  : divisor;

    // r_q < d_q always holds, so a clear top bit of r_sub means no borrow.
    assign r_sh  = {r_q, q_q[DATA_W-1]};
    assign r_sub = r_sh - {1'b0, d_q};
    assign ge    = ~r_sub[DATA_W];
    assign r_nxt = ge ? r_sub[DATA_W-1:0] : r_sh[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else if (abort) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        cnt_q <= '0;
                        if (divisor == '0) begin
                            state_q <= DIV_DONE;
                            dz_q    <= 1'b1;
                        end else begin
                            state_q <= DIV_BUSY;
                            dz_q    <= 1'b0;
                            q_q     <= mag_a;
                            d_q     <= mag_b;
                            r_q     <= '0;
                            qneg_q  <= signed_en & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                            rneg_q  <= signed_en & dividend[DATA_W-1];
                        end
                    end
                end
                DIV_BUSY: begin
                    q_q   <= {q_q[DATA_W-2:0], ge};
                    r_q   <= r_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= DIV_DONE;
                end
                DIV_DONE: state_q <= DIV_IDLE;
                default:  state_q <= DIV_IDLE;
            endcase
        end
    end

    assign busy      = rst & ~abort & (((state_q == DIV_IDLE) & start) | (state_q == DIV_BUSY));
    assign done      = rst & ~abort & (state_q == DIV_DONE) & ~dz_q;
    assign quotient  = qneg_q ? -q_q : q_q;
    assign remainder = rneg_q ? -r_q : r_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, single-cycle multiply, HI/LO pair and an
// iterative divider. Signed-overflow trapping is built with OVERFLOW_TRAP_EN.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W   = BUS_W,
    parameter int DIV_ITER = BUS_W
) (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave ex
);
    logic [DATA_W-1:0]   op1, op2;
    logic [DATA_W-1:0]   add_res, sub_res, alu_res;
    logic [2*DATA_W-1:0] prod_s, prod_u;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0]   div_q, div_r;
    logic                is_div, is_div_s, hilo_op, ovf;
    logic                div_busy, div_done;

    assign op1     = ex.operand_1;
    assign op2     = ex.operand_2;
    assign add_res = op1 + op2;
    assign sub_res = op1 - op2;
    assign prod_s  = $signed({{DATA_W{op1[DATA_W-1]}}, op1}) * $signed({{DATA_W{op2[DATA_W-1]}}, op2});
    assign prod_u  = {{DATA_W{1'b0}}, op1} * {{DATA_W{1'b0}}, op2};

    assign is_div_s = (ex.funct == F_DIV);
    assign is_div   = is_div_s | (ex.funct == F_DIVU);
    assign hilo_op  = is_div | (ex.funct == F_MULT) | (ex.funct == F_MULTU)
                    | (ex.funct == F_MTHI) | (ex.funct == F_MTLO);

`ifdef OVERFLOW_TRAP_EN
    assign ovf = ((ex.funct == F_ADD) && (op1[DATA_W-1] == op2[DATA_W-1])
                                      && (add_res[DATA_W-1] != op1[DATA_W-1]))
              || ((ex.funct == F_SUB) && (op1[DATA_W-1] != op2[DATA_W-1])
                                      && (sub_res[DATA_W-1] != op1[DATA_W-1]));
`else
    assign ovf = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        case (ex.funct)
            F_ADD, F_ADDU: alu_res = add_res;
            F_SUB, F_SUBU: alu_res = sub_res;
            F_AND:  alu_res = op1 & op2;
            F_OR:   alu_res = op1 | op2;
            F_XOR:  alu_res = op1 ^ op2;
            F_NOR:  alu_res = ~(op1 | op2);
            F_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
            F_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op1 < op2)};
            F_SLL:  alu_res = op2 << ex.shamt;
            F_SRL:  alu_res = op2 >> ex.shamt;
            F_SRA:  alu_res = $signed(op2) >>> ex.shamt;
            F_SLLV: alu_res = op2 << op1[4:0];
            F_SRLV: alu_res = op2 >> op1[4:0];
            F_SRAV: alu_res = $signed(op2) >>> op1[4:0];
            F_MFHI: alu_res = hi_q;
            F_MFLO: alu_res = lo_q;
            F_JALR: alu_res = op1;
            default: alu_res = '0;
        endcase
    end

    div_unit #(
        .DATA_W   (DATA_W),
        .DIV_ITER (DIV_ITER)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div),
        .signed_en (is_div_s),
        .abort     (ex.flush),
        .dividend  (op1),
        .divisor   (op2),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // A flushed instruction must not commit HI/LO.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_done) begin
            hi_d = div_r;
            lo_d = div_q;
        end else if (!ex.flush) begin
            case (ex.funct)
                F_MULT:  {hi_d, lo_d} = prod_s;
                F_MULTU: {hi_d, lo_d} = prod_u;
                F_MTHI:  hi_d = op1;
                F_MTLO:  lo_d = op1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign ex.result             = rst ? alu_res : '0;
    assign ex.write_reg_en_out   = rst & ex.write_reg_en_in & ~hilo_op & ~ovf;
    assign ex.write_reg_addr_out = rst ? ex.write_reg_addr_in : '0;
    assign ex.stall_req          = div_busy;
    assign ex.overflow_exc       = rst & ovf;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected outputs are queued when an
// instruction is driven and compared when the stage presents its result.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_stage_if #(.DATA_W(32)) bus ();
    ex_stage #(.DATA_W(32), .DIV_ITER(32)) dut (.clk(clk), .rst(rst), .ex(bus));

`ifdef OVERFLOW_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct { string name; logic [31:0] res; logic wen; logic ovf; } exp_t;
    typedef struct { string name; logic [5:0] f; logic [4:0] sh; logic [31:0] a, b, res; logic wen, ovf; } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic issue(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
        bus.flush             = 1'b0;
        bus.funct             = f;
        bus.shamt             = sh;
        bus.operand_1         = a;
        bus.operand_2         = b;
        bus.write_reg_en_in   = 1'b1;
        bus.write_reg_addr_in = 5'd9;
    endtask

    task automatic test_reset;
        exp_t e;
        rst = 1'b0;
        issue(F_ADDU, 5'd0, 32'd1, 32'd2);
        sb.push_back('{"reset_outputs", 32'd0, 1'b0, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (bus.result !== e.res || bus.write_reg_en_out !== e.wen || bus.overflow_exc !== e.ovf
            || bus.stall_req !== 1'b0 || bus.write_reg_addr_out !== 5'd0) begin
            errors++;
            $display("FAIL %s: result=%h wen=%b ovf=%b stall=%b addr=%0d, expected all zero",
                     e.name, bus.result, bus.write_reg_en_out, bus.overflow_exc, bus.stall_req, bus.write_reg_addr_out);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        issue(F_MFHI, 5'd0, 32'd0, 32'd0);
        sb.push_back('{"reset_hi", 32'd0, 1'b1, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (bus.result !== e.res || bus.write_reg_en_out !== e.wen || bus.write_reg_addr_out !== 5'd9) begin
            errors++;
            $display("FAIL %s: result=%h wen=%b addr=%0d, expected %h %b 9", e.name, bus.result, bus.write_reg_en_out, bus.write_reg_addr_out, e.res, e.wen);
        end
        @(posedge clk); #1;
        issue(F_MFLO, 5'd0, 32'd0, 32'd0);
        sb.push_back('{"reset_lo", 32'd0, 1'b1, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (bus.result !== e.res || bus.write_reg_en_out !== e.wen) begin
            errors++;
            $display("FAIL %s: result=%h wen=%b, expected %h %b", e.name, bus.result, bus.write_reg_en_out, e.res, e.wen);
        end
    endtask

    task automatic test_alu;
        vec_t v[$];
        exp_t e;
        logic [31:0] a, b;
        v.push_back('{"add_ovf",  F_ADD,  5'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, !TRAP, TRAP});
        v.push_back('{"add_ok",   F_ADD,  5'd0,  32'd1,        32'd2,        32'd3,        1'b1,  1'b0});
        v.push_back('{"sub_ovf",  F_SUB,  5'd0,  32'h80000000, 32'h1,        32'h7FFFFFFF, !TRAP, TRAP});
        v.push_back('{"addu_wrap",F_ADDU, 5'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1,  1'b0});
        v.push_back('{"subu",     F_SUBU, 5'd0,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b1,  1'b0});
        v.push_back('{"and",      F_AND,  5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b1,  1'b0});
        v.push_back('{"or",       F_OR,   5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b1,  1'b0});
        v.push_back('{"xor",      F_XOR,  5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b1,  1'b0});
        v.push_back('{"nor",      F_NOR,  5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b1,  1'b0});
        v.push_back('{"slt",      F_SLT,  5'd0,  32'hFFFFFFFF, 32'h1,        32'd1,        1'b1,  1'b0});
        v.push_back('{"sltu",     F_SLTU, 5'd0,  32'hFFFFFFFF, 32'h1,        32'd0,        1'b1,  1'b0});
        v.push_back('{"sra",      F_SRA,  5'd4,  32'd0,        32'h80000000, 32'hF8000000, 1'b1,  1'b0});
        v.push_back('{"srl",      F_SRL,  5'd4,  32'd0,        32'h80000000, 32'h08000000, 1'b1,  1'b0});
        v.push_back('{"sll31",    F_SLL,  5'd31, 32'd0,        32'd3,        32'h80000000, 1'b1,  1'b0});
        v.push_back('{"srlv",     F_SRLV, 5'd0,  32'd36,       32'hF0,       32'h0000000F, 1'b1,  1'b0});
        v.push_back('{"sllv",     F_SLLV, 5'd0,  32'd33,       32'd1,        32'd2,        1'b1,  1'b0});
        v.push_back('{"srav",     F_SRAV, 5'd0,  32'd8,        32'h80000000, 32'hFF800000, 1'b1,  1'b0});
        v.push_back('{"jalr",     F_JALR, 5'd0,  32'h00400010, 32'd0,        32'h00400010, 1'b1,  1'b0});
        v.push_back('{"unknown",  6'h3F,  5'd0,  32'd5,        32'd6,        32'd0,        1'b1,  1'b0});
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom;
            v.push_back('{"rnd_addu", F_ADDU, 5'd0, a, b, a + b, 1'b1, 1'b0});
            v.push_back('{"rnd_subu", F_SUBU, 5'd0, a, b, a - b, 1'b1, 1'b0});
        end
        foreach (v[i]) begin
            @(posedge clk); #1;
            issue(v[i].f, v[i].sh, v[i].a, v[i].b);
            sb.push_back('{v[i].name, v[i].res, v[i].wen, v[i].ovf});
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (bus.result !== e.res || bus.write_reg_en_out !== e.wen || bus.overflow_exc !== e.ovf) begin
                errors++;
                $display("FAIL %s: result=%h wen=%b ovf=%b, expected %h %b %b",
                         e.name, bus.result, bus.write_reg_en_out, bus.overflow_exc, e.res, e.wen, e.ovf);
            end
        end
    endtask

    task automatic test_mult;
        vec_t v[$];
        exp_t e;
        v.push_back('{"mult",       F_MULT,  5'd0, 32'hFFFFFFFF, 32'd2, 32'd0,        1'b0, 1'b0});
        v.push_back('{"mult_hi",    F_MFHI,  5'd0, 32'd0,        32'd0, 32'hFFFFFFFF, 1'b1, 1'b0});
        v.push_back('{"mult_lo",    F_MFLO,  5'd0, 32'd0,        32'd0, 32'hFFFFFFFE, 1'b1, 1'b0});
        v.push_back('{"multu",      F_MULTU, 5'd0, 32'hFFFFFFFF, 32'd2, 32'd0,        1'b0, 1'b0});
        v.push_back('{"multu_hi",   F_MFHI,  5'd0, 32'd0,        32'd0, 32'd1,        1'b1, 1'b0});
        v.push_back('{"multu_lo",   F_MFLO,  5'd0, 32'd0,        32'd0, 32'hFFFFFFFE, 1'b1, 1'b0});
        v.push_back('{"mthi",       F_MTHI,  5'd0, 32'h11,       32'd0, 32'd0,        1'b0, 1'b0});
        v.push_back('{"mtlo",       F_MTLO,  5'd0, 32'h22,       32'd0, 32'd0,        1'b0, 1'b0});
        v.push_back('{"mthi_rd",    F_MFHI,  5'd0, 32'd0,        32'd0, 32'h11,       1'b1, 1'b0});
        v.push_back('{"mtlo_rd",    F_MFLO,  5'd0, 32'd0,        32'd0, 32'h22,       1'b1, 1'b0});
        foreach (v[i]) begin
            @(posedge clk); #1;
            issue(v[i].f, v[i].sh, v[i].a, v[i].b);
            sb.push_back('{v[i].name, v[i].res, v[i].wen, v[i].ovf});
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (bus.result !== e.res || bus.write_reg_en_out !== e.wen || bus.stall_req !== 1'b0) begin
                errors++;
                $display("FAIL %s: result=%h wen=%b stall=%b, expected %h %b 0",
                         e.name, bus.result, bus.write_reg_en_out, bus.stall_req, e.res, e.wen);
            end
        end
    endtask

    task automatic test_div_case(input string n, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input int exp_stall, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        exp_t e;
        int   n_stall = 0;
        bit   seen_end = 1'b0;
        @(posedge clk); #1;
        issue(f, 5'd0, a, b);
        sb.push_back('{{n, "_lo"}, exp_lo, 1'b1, 1'b0});
        sb.push_back('{{n, "_hi"}, exp_hi, 1'b1, 1'b0});
        @(negedge clk);
        checks++;
        if (bus.write_reg_en_out !== 1'b0 || bus.result !== 32'd0) begin
            errors++;
            $display("FAIL %s_issue: result=%h wen=%b, expected 0 0", n, bus.result, bus.write_reg_en_out);
        end
        for (int c = 0; c < 100 && !seen_end; c++) begin
            if (bus.stall_req === 1'b1) n_stall++;
            else seen_end = 1'b1;
            if (!seen_end) @(negedge clk);
        end
        checks++;
        if (!seen_end || n_stall != exp_stall) begin
            errors++;
            $display("FAIL %s_stall: stall cycles=%0d ended=%b, expected %0d", n, n_stall, seen_end, exp_stall);
        end
        @(posedge clk); #1;
        issue(F_MFLO, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (bus.result !== e.res || bus.write_reg_en_out !== e.wen || bus.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL %s: result=%h wen=%b stall=%b, expected %h %b 0", e.name, bus.result, bus.write_reg_en_out, bus.stall_req, e.res, e.wen);
        end
        @(posedge clk); #1;
        issue(F_MFHI, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (bus.result !== e.res || bus.write_reg_en_out !== e.wen) begin
            errors++;
            $display("FAIL %s: result=%h wen=%b, expected %h %b", e.name, bus.result, bus.write_reg_en_out, e.res, e.wen);
        end
    endtask

    task automatic test_flush_and_reset;
        exp_t e;
        // HI=0x11, LO=0x22 left by test_div_case dz run
        @(posedge clk); #1;
        issue(F_DIVU, 5'd0, 32'd100, 32'd7);
        repeat (11) @(posedge clk);
        #1;
        checks++;
        if (bus.stall_req !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre: stall=%b, expected 1", bus.stall_req);
        end
        bus.flush = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_same_cycle: stall=%b, expected 0", bus.stall_req);
        end
        @(posedge clk); #1;
        issue(F_MFHI, 5'd0, 32'd0, 32'd0);
        sb.push_back('{"flush_hi", 32'h11, 1'b1, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (bus.result !== e.res || bus.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL %s: result=%h stall=%b, expected %h 0", e.name, bus.result, bus.stall_req, e.res);
        end
        @(posedge clk); #1;
        issue(F_MFLO, 5'd0, 32'd0, 32'd0);
        sb.push_back('{"flush_lo", 32'h22, 1'b1, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (bus.result !== e.res || bus.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL %s: result=%h stall=%b, expected %h 0", e.name, bus.result, bus.stall_req, e.res);
        end

        @(posedge clk); #1;
        issue(F_DIVU, 5'd0, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stall_req !== 1'b0 || bus.result !== 32'd0 || bus.write_reg_en_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_div: stall=%b result=%h wen=%b, expected 0 0 0", bus.stall_req, bus.result, bus.write_reg_en_out);
        end
        @(posedge clk); #1 rst = 1'b1;
        issue(F_MFHI, 5'd0, 32'd0, 32'd0);
        sb.push_back('{"rst_div_hi", 32'd0, 1'b1, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (bus.result !== e.res || bus.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL %s: result=%h stall=%b, expected %h 0", e.name, bus.result, bus.stall_req, e.res);
        end
        @(posedge clk); #1;
        issue(F_MFLO, 5'd0, 32'd0, 32'd0);
        sb.push_back('{"rst_div_lo", 32'd0, 1'b1, 1'b0});
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (bus.result !== e.res || bus.stall_req !== 1'b0) begin
            errors++;
            $display("FAIL %s: result=%h stall=%b, expected %h 0", e.name, bus.result, bus.stall_req, e.res);
        end
    endtask

    initial begin
        issue(F_SLL, 5'd0, 32'd0, 32'd0);
        test_reset();
        test_alu();
        test_mult();
        test_div_case("div_neg", F_DIV, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF);
        test_div_case("divu", F_DIVU, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        @(posedge clk); #1; issue(F_MTHI, 5'd0, 32'h11, 32'd0);
        @(posedge clk); #1; issue(F_MTLO, 5'd0, 32'h22, 32'd0);
        test_div_case("div_zero", F_DIV, 32'd5, 32'd0, 1, 32'h22, 32'h11);
        test_flush_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage directly downstream of instruction decode.
- Consumes decoded funct/shamt/operand_1/operand_2 and the write-back target, and produces the ALU result for the memory stage.
- Owns the HI/LO register pair: single-cycle MULT/MULTU and a 32-iteration radix-2 DIV/DIVU FSM.
- Raises stall_req while a division is in flight.

Parameters:
- DATA_W, 32, operand/result width (matches the shared data bus width)
- DIV_ITER, 32, divider iterations; must equal DATA_W

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- flush  in  1  exception flush; aborts in-flight divide
- funct  in  6  operation, MIPS SPECIAL funct encoding; immediate/link forms arrive pre-mapped by decode
- shamt  in  5  constant shift amount
- operand_1  in  32  rs value, or link address for JAL/JALR/BxxZAL
- operand_2  in  32  rt value or extended immediate
- write_reg_en_in  in  1  decode write-enable
- write_reg_addr_in  in  5  decode destination register
- result  out  32  execute result
- write_reg_en_out  out  1  qualified write-enable
- write_reg_addr_out  out  5  passthrough of write_reg_addr_in
- stall_req  out  1  hold IF/ID/EX inputs stable
- overflow_exc  out  1  signed-overflow exception (optional feature)

Behaviour:
- Reset: on a clk edge with rst==0: HI=LO=0, divider state IDLE, iteration count 0. While rst==0, all outputs are combinationally 0.
- result is combinational, with zero added latency:
  - ADD/ADDU: op1+op2. SUB/SUBU: op1-op2.
  - AND/OR/XOR/NOR: bitwise.
  - SLT: signed compare, result 0 or 1. SLTU: unsigned compare, result 0 or 1.
  - SLL/SRL/SRA: shift op2 by shamt. SLLV/SRLV/SRAV: shift op2 by op1[4:0].
  - MFHI: HI. MFLO: LO. JALR: op1.
  - Unknown funct: 0.
- write_reg_en_out = write_reg_en_in, except it is forced 0 for MULT/MULTU/DIV/DIVU/MTHI/MTLO and on an overflow trap.
- MULT/MULTU: full 64-bit signed/unsigned product. {HI,LO} is written at the clock edge ending the cycle.
- MTHI/MTLO: op1 is written to HI/LO at the clock edge.
- Re-execution of these instructions while held is idempotent.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE + DIV/DIVU + op2!=0: stall_req=1. Latch |op1|, |op2| and the quotient/remainder signs (DIVU: raw values). Go to BUSY with count=0.
  - BUSY: one restoring shift-subtract iteration per cycle, stall_req=1. After count==DIV_ITER-1, go to DONE.
  - DONE: stall_req=0. Sign-corrected quotient goes to LO, remainder to HI, both written at this edge. Go to IDLE.
  - Latency: 34 cycles total, 33 with stall_req asserted.
  - Divide by zero: IDLE goes to DONE directly, with 1 stall cycle. HI/LO are unchanged.
  - Remainder sign follows the dividend. Example: DIV -7,2 gives LO=-3, HI=-1.
- flush in any state: go to IDLE next edge, no HI/LO write, stall_req deasserted the same cycle. flush takes priority over DONE.
- Reset mid-divide: go to IDLE, HI/LO cleared.
- MFHI/MFLO issued directly after MULT/MTxx/DIV-DONE sees the updated value, because the write lands at the edge before that instruction executes in EX.

Optional Feature:
- Macro: OVERFLOW_TRAP_EN
- Defined:
  - ADD/SUB (including ADDI, which decode maps to ADD) with signed overflow drives overflow_exc=1 and write_reg_en_out=0.
  - Overflow is detected when the operand signs match (ADD) or differ (SUB) and the result sign differs from op1.
- Undefined: overflow_exc tied 0; ADD behaves as ADDU and SUB as SUBU.

Decomposition:
- Shared headers:
  - funct codes in existing funct.v.
  - Bus widths in bus.v.
  - Add a div-state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) to a new shared exec_defs.v.
- One sub-module: div_unit.
  - Contains the FSM, counter, partial remainder and sign correction.
  - Interface: start, signed_en, abort, dividend, divisor, busy, done, quotient, remainder.
- ex_stage keeps the ALU mux, multiplier, HI/LO registers and write-enable qualification.

Test Plan:
1. ADD 0x7FFFFFFF,1 -> result 0x80000000. With OVERFLOW_TRAP_EN: overflow_exc=1, write_reg_en_out=0. Without it: write_reg_en_out=1.
2. SRA op2=0x80000000 shamt=4 -> 0xF8000000. SRLV op1=36 op2=0xF0 -> shift by 4, result 0x0000000F.
3. MULT 0xFFFFFFFF(-1),2 then MFHI, MFLO -> 0xFFFFFFFF, 0xFFFFFFFE. MULTU same operands -> HI=1, LO=0xFFFFFFFE.
4. DIV -7,2 held stable -> stall_req high exactly 33 cycles. Then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100,7 -> LO=14, HI=2.
5. DIV 5,0 -> stall_req high 1 cycle; HI/LO keep prior values (seed HI=0x11, LO=0x22 via MTHI/MTLO).
6. DIV started, flush at BUSY count=10 -> next cycle IDLE, stall_req=0, HI/LO unchanged. rst=0 mid-divide -> HI=LO=0, IDLE.
